// File: rtl/serial_op_sequencer_pkg.sv
// Shared types and constants for the bit-serial register-file sequencer.
package serial_pkg;

  localparam int XLEN_C = 32;
  localparam int NREG_C = 16;

  typedef enum logic [2:0] {
    OP_MOV  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_SLTU = 3'd4,
    OP_SLT  = 3'd5,
    OP_SEQ  = 3'd6,
    OP_CMP  = 3'd7
  } serial_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2,
    ST_FIN  = 2'd3
  } seq_state_e;

  // Streaming ops write their result bit in the same cycle the operands arrive.
  function automatic logic op_is_stream(serial_op_e op);
    return (op inside {OP_MOV, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/serial_op_sequencer_cmp.sv
// MSB-first magnitude/equality tracker: the first differing bit decides lt.
module serial_cmp_unit
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic sign_first_i,
  input  logic a_i,
  input  logic b_i,
  output logic eq_o,
  output logic lt_o
);

  logic eq_q, eq_d;
  logic lt_q, lt_d;

  // Once a difference is seen the result is frozen; on the sign bit the
  // ordering inverts, so a set 'a' means a is the negative (smaller) one.
  always_comb begin
    eq_d = eq_q;
    lt_d = lt_q;
    if (clr_i) begin
      eq_d = 1'b1;
      lt_d = 1'b0;
    end else if (en_i && eq_q && (a_i != b_i)) begin
      eq_d = 1'b0;
      lt_d = sign_first_i ? a_i : b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q <= 1'b1;
      lt_q <= 1'b0;
    end else begin
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end

  assign eq_o = eq_q;
  assign lt_o = lt_q;

endmodule

// File: rtl/serial_op_sequencer.sv
// Issue controller for the bit-serial 16 x XLEN register file.
// Optional compare flags (cmp_lt/cmp_eq, op 7 = CMP) under SERIAL_SEQ_CMP_FLAG_EN.
module serial_op_sequencer
  import serial_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_rd,
  input  logic [3:0] req_rs1,
  input  logic [3:0] req_rs2,
  output logic [3:0] r_sel1,
  output logic [3:0] r_sel2,
  input  logic       r_value1,
  input  logic       r_value2,
  output logic       shift,
  output logic       wr_en,
  output logic [3:0] write_register,
  output logic       write_value,
  output logic       busy,
`ifdef SERIAL_SEQ_CMP_FLAG_EN
  output logic       done,
  output logic       cmp_lt,
  output logic       cmp_eq
`else
  output logic       done
`endif
);

  // Handshake: a request is taken on the edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests during busy are dropped.
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  serial_op_e       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [3:0]       rs1_q, rs1_d;
  logic [3:0]       rs2_q, rs2_d;

  logic cmp_clr, cmp_en, sign_first;
  logic eq_w, lt_w;
  logic last_bit;
  logic stream_bit;

  assign last_bit = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    case (op_q)
      OP_MOV:  stream_bit = r_value1;
      OP_AND:  stream_bit = r_value1 & r_value2;
      OP_OR:   stream_bit = r_value1 | r_value2;
      OP_XOR:  stream_bit = r_value1 ^ r_value2;
      default: stream_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    rd_d           = rd_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    cmp_clr        = 1'b0;
    cmp_en         = 1'b0;
    sign_first     = 1'b0;
    req_ready      = 1'b0;
    busy           = 1'b1;
    shift          = 1'b0;
    wr_en          = 1'b0;
    write_register = 4'd0;
    write_value    = 1'b0;
    r_sel1         = 4'd0;
    r_sel2         = 4'd0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        cmp_clr   = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          op_d  = serial_op_e'(req_op);
          rd_d  = req_rd;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
`ifdef SERIAL_SEQ_CMP_FLAG_EN
          state_d = ST_RUN;
`else
          state_d = (serial_op_e'(req_op) == OP_CMP) ? ST_FIN : ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        shift          = 1'b1;
        r_sel1         = rs1_q;
        r_sel2         = rs2_q;
        write_register = rd_q;
        cmp_en         = 1'b1;
        sign_first     = (op_q == OP_SLT) && (cnt_q == '0);
        // x0 still rotates with everyone else but is never written.
        if (op_is_stream(op_q)) begin
          wr_en       = (rd_q != 4'd0);
          write_value = stream_bit;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = (op_q inside {OP_SLTU, OP_SLT, OP_SEQ}) ? ST_WB : ST_FIN;
        end
      end
      ST_WB: begin
        shift          = 1'b1;
        write_register = rd_q;
        wr_en          = (rd_q != 4'd0);
        cnt_d          = cnt_q + CNT_W'(1);
        if (last_bit) begin
          write_value = (op_q == OP_SEQ) ? eq_w : lt_w;
          cnt_d       = '0;
          state_d     = ST_FIN;
        end
      end
      default: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MOV;
      rd_q    <= 4'd0;
      rs1_q   <= 4'd0;
      rs2_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  serial_cmp_unit u_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cmp_clr),
    .en_i         (cmp_en),
    .sign_first_i (sign_first),
    .a_i          (r_value1),
    .b_i          (r_value2),
    .eq_o         (eq_w),
    .lt_o         (lt_w)
  );

`ifdef SERIAL_SEQ_CMP_FLAG_EN
  logic cmp_lt_q, cmp_eq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_lt_q <= 1'b0;
      cmp_eq_q <= 1'b0;
    end else if ((state_q == ST_FIN) && !op_is_stream(op_q)) begin
      cmp_lt_q <= lt_w;
      cmp_eq_q <= eq_w;
    end
  end

  assign cmp_lt = cmp_lt_q;
  assign cmp_eq = cmp_eq_q;
`endif

endmodule

// File: tb/tb_serial_op_sequencer.sv
// Directed + random bench for serial_op_sequencer with a behavioural register file.
module tb_serial_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [3:0]  req_rd = 4'd0;
  logic [3:0]  req_rs1 = 4'd0;
  logic [3:0]  req_rs2 = 4'd0;
  logic [3:0]  r_sel1, r_sel2;
  logic        r_value1, r_value2;
  logic        shift, wr_en, write_value, busy, done;
  logic [3:0]  write_register;
`ifdef SERIAL_SEQ_CMP_FLAG_EN
  logic        cmp_lt, cmp_eq;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  serial_op_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_rd         (req_rd),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .r_sel1         (r_sel1),
    .r_sel2         (r_sel2),
    .r_value1       (r_value1),
    .r_value2       (r_value2),
    .shift          (shift),
    .wr_en          (wr_en),
    .write_register (write_register),
    .write_value    (write_value),
    .busy           (busy),
`ifdef SERIAL_SEQ_CMP_FLAG_EN
    .done           (done),
    .cmp_lt         (cmp_lt),
    .cmp_eq         (cmp_eq)
`else
    .done           (done)
`endif
  );

  // ---------------- register file model ----------------
  logic [31:0] rf [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_val = 32'd0;

  assign r_value1 = rf[r_sel1][31];
  assign r_value2 = rf[r_sel2][31];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
    end else begin
      if (shift) begin
        for (int i = 0; i < 16; i++)
          rf[i] <= (wr_en && write_register == 4'(i)) ? {rf[i][30:0], write_value}
                                                       : {rf[i][30:0], rf[i][31]};
      end
      if (pl_en) rf[pl_idx] <= pl_val;
    end
  end

  // ---------------- event counters ----------------
  int acc_cnt = 0;
  int wr_cnt = 0;
  int sh_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) acc_cnt++;
    if (wr_en) wr_cnt++;
    if (shift) sh_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] old);
    case (op)
      3'd0: return a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return {31'd0, a < b};
      3'd5: return {31'd0, $signed(a) < $signed(b)};
      3'd6: return {31'd0, a == b};
      default: return old;
    endcase
  endfunction

  // Cycles from the accept edge through the edge closing the done cycle.
  function automatic int model_lat(input logic [2:0] op);
    if (op inside {3'd4, 3'd5, 3'd6}) return 65;
`ifdef SERIAL_SEQ_CMP_FLAG_EN
    return 33;
`else
    return (op == 3'd7) ? 1 : 33;
`endif
  endfunction

  function automatic int model_passes(input logic [2:0] op);
    return model_lat(op) / 32;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, 32'({req_ready, busy, shift, wr_en, done, write_value}), 32'h20);
    check({tag, " sel"}, 32'({r_sel1, r_sel2, write_register}), 32'h0);
`ifdef SERIAL_SEQ_CMP_FLAG_EN
    check({tag, " flags"}, 32'({cmp_lt, cmp_eq}), 32'h0);
`endif
  endtask

  // Issue one op, push its expected rd value, then compare when done arrives.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input bit hold);
    int n;
    int rdy_bad;
    int acc0, wr0, sh0;
    int exp_wr;
    exp_q.push_back((rd == 4'd0) ? rf[0] : model(op, rf[rs1], rf[rs2], rf[rd]));
    exp_wr = (rd == 4'd0 || op == 3'd7) ? 0 : 32;
    acc0 = acc_cnt; wr0 = wr_cnt; sh0 = sh_cnt; rdy_bad = 0;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_op = 3'($urandom_range(0, 7));
    req_rd = 4'($urandom_range(0, 15));
    req_rs1 = 4'($urandom_range(0, 15));
    req_rs2 = 4'($urandom_range(0, 15));
    n = 0;
    while (!done && n < 200) begin
      if (req_ready) rdy_bad++;
      @(posedge clk); #1;
      n++;
    end
    if (req_ready) rdy_bad++;
    req_valid = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(n + 1), 32'(model_lat(op)));
    check({tag, " ready_low_while_busy"}, 32'(rdy_bad), 32'd0);
    @(posedge clk); #1;
    check({tag, " back_idle"}, 32'({req_ready, busy, done}), 32'b100);
    check({tag, " accepts"}, 32'(acc_cnt - acc0), 32'd1);
    check({tag, " shifts"}, 32'(sh_cnt - sh0), 32'(32 * model_passes(op)));
    check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, " rd_value"}, rf[rd], exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] x1_v, x2_v;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    x1_v = 32'hF0F0_1234;
    x2_v = 32'h0FF0_00FF;
    preload(4'd1, x1_v);
    preload(4'd2, x2_v);
    preload(4'd7, 32'hDEAD_BEEF);

    run_op("xor", 3'd3, 4'd3, 4'd1, 4'd2, 1'b0);
    check("xor x3_const", rf[3], 32'hFF00_12CB);
    check("xor x1_kept", rf[1], x1_v);
    check("xor x2_kept", rf[2], x2_v);

    run_op("sltu", 3'd4, 4'd4, 4'd2, 4'd1, 1'b0);
    check("sltu x4_const", rf[4], 32'd1);
    run_op("slt", 3'd5, 4'd4, 4'd2, 4'd1, 1'b0);
    check("slt x4_const", rf[4], 32'd0);
    run_op("seq", 3'd6, 4'd5, 4'd7, 4'd7, 1'b0);
    check("seq x5_const", rf[5], 32'd1);
    run_op("and_rd0", 3'd1, 4'd0, 4'd1, 4'd2, 1'b0);
    run_op("mov_hold_valid", 3'd0, 4'd8, 4'd7, 4'd7, 1'b1);
    run_op("xor_rd_eq_rs1", 3'd3, 4'd2, 4'd2, 4'd1, 1'b0);
    check("xor_rd_eq_rs1 x2_const", rf[2], x1_v ^ x2_v);

    for (int i = 0; i < 6; i++) begin
      preload(4'($urandom_range(1, 15)), $urandom);
      run_op("random", 3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end

    // Abort an OR ten cycles into its RUN pass.
    req_valid = 1'b1; req_op = 3'd2; req_rd = 4'd6; req_rs1 = 4'd1; req_rs2 = 4'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort in_run", 32'({busy, shift}), 32'b11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mov_after_clear", 3'd0, 4'd6, 4'd1, 4'd1, 1'b0);
    check("mov_after_clear x6_const", rf[6], 32'd0);

    preload(4'd1, 32'd5);
    preload(4'd2, 32'd9);
    preload(4'd3, 32'h1234_5678);
    run_op("cmp", 3'd7, 4'd3, 4'd1, 4'd2, 1'b0);
    check("cmp x3_untouched", rf[3], 32'h1234_5678);
`ifdef SERIAL_SEQ_CMP_FLAG_EN
    check("cmp flags", 32'({cmp_lt, cmp_eq}), 32'b10);
    run_op("cmp_equal", 3'd7, 4'd3, 4'd2, 4'd2, 1'b0);
    check("cmp_equal flags", 32'({cmp_lt, cmp_eq}), 32'b01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "simulation time limit reached");
  end

endmodule
